data_memory_access_controller: RTL and testbench
================================================

// Module: data_memory_access_controller
// PURPOSE
//  Sequences MEM-stage loads/stores onto a variable-latency data memory using a req/ready handshake.
//  Stalls the pipeline (StallM) until the access completes and presents ReadDataM to the MEM/WB register.
//  A bounded timeout turns a hung access into a sticky bus error instead of deadlocking the pipeline.
// PARAMETERS
//  DATA_WIDTH      32  width of load/store data
//  ADDR_WIDTH      32  width of byte address (ALUOutM)
//  TIMEOUT_CYCLES  16  maximum ACCESS cycles without mem_ready before abort (>=1)
//  CNT_WIDTH        5  timeout counter width; must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES
// PORTS
//  CLK         in   1           clock, rising edge
//  RST         in   1           asynchronous reset, active-high
//  MemReadM    in   1           MEM-stage load request
//  MemWriteM   in   1           MEM-stage store request
//  ALUOutM     in   ADDR_WIDTH  access address
//  WriteDataM  in   DATA_WIDTH  store data
//  mem_rdata   in   DATA_WIDTH  memory read data, valid with mem_ready
//  mem_ready   in   1           memory completion strobe
//  mem_req     out  1           access request to memory (registered)
//  mem_we      out  1           1 = write, 0 = read (registered)
//  mem_addr    out  ADDR_WIDTH  latched address (registered)
//  mem_wdata   out  DATA_WIDTH  latched store data (registered)
//  StallM      out  1           freeze IF..MEM pipeline registers (combinational from state/inputs)
//  ReadDataM   out  DATA_WIDTH  load result for MEM/WB register (registered)
//  BusErrM     out  1           sticky timeout flag (registered)
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, BusErrM, counter = 0.
//   Reset mid-access drops mem_req immediately; the in-flight access is abandoned.
//  States: IDLE, ACCESS, DONE.
//  IDLE: if MemReadM|MemWriteM: latch ALUOutM->mem_addr, WriteDataM->mem_wdata, MemWriteM->mem_we;
//   mem_req<=1; counter<=0; ->ACCESS. StallM=1 in this cycle. No request: StallM=0, stay IDLE.
//  Both MemReadM and MemWriteM high: treated as a store; ReadDataM<=0 on completion.
//  ACCESS: StallM=1; mem_req, mem_we, mem_addr, mem_wdata held stable.
//   mem_ready=1: mem_req<=0; ReadDataM<=mem_rdata if read, else ReadDataM unchanged; ->DONE.
//   mem_ready=0 and counter==TIMEOUT_CYCLES-1: mem_req<=0; BusErrM<=1; ReadDataM<=0; ->DONE.
//   otherwise counter<=counter+1 (no wrap: abort occurs before overflow).
//  DONE: StallM=0 so the pipeline advances exactly once on this edge; MemReadM/MemWriteM ignored; ->IDLE.
//  mem_ready outside ACCESS is ignored. mem_rdata is sampled only on the completing edge.
//  Latency: zero-wait memory (ready in first ACCESS cycle) costs 2 stall cycles per access;
//   each extra wait cycle adds 1; timeout abort costs TIMEOUT_CYCLES+1 stall cycles.
//  Back-to-back accesses: the next request is detected in the IDLE cycle following DONE.
//  BusErrM clears only on RST; later accesses proceed normally while it stays set.
// TESTING
//  1 Reset: RST pulsed mid-ACCESS -> mem_req, StallM(with no req), ReadDataM, BusErrM all 0 at once.
//  2 Zero-wait load: MemReadM=1, ALUOutM=0x100, ready in 1st ACCESS cycle, rdata=0xDEADBEEF
//    -> StallM high 2 cycles, mem_we=0, ReadDataM=0xDEADBEEF in DONE.
//  3 Store with 3 wait cycles: MemWriteM=1, addr=0x44, data=0x12345678 -> mem_we=1, addr/data stable
//    for 4 ACCESS cycles, StallM high 5 cycles, ReadDataM unchanged.
//  4 Timeout: load, mem_ready never asserted -> mem_req drops after 16 ACCESS cycles, BusErrM=1,
//    ReadDataM=0; next load with ready completes normally, BusErrM stays 1.
//  5 Back-to-back: load then store in consecutive instructions -> two separate mem_req pulses,
//    one IDLE cycle between them; stray mem_ready in IDLE/DONE has no effect.
//  6 MemReadM=MemWriteM=1 -> mem_we=1, ReadDataM=0 on completion.

Source files
------------

// File: rtl/data_memory_access_controller.sv
// rtl/data_memory_access_controller.sv - MEM-stage data memory access sequencer with stall and timeout
//
// Purpose:
//   Turns MEM-stage load/store requests into a req/ready transaction on a
//   variable-latency data memory. The pipeline is held by StallM until the
//   access completes. A hung access is aborted after TIMEOUT_CYCLES and
//   raises a sticky bus error.
//
// Ports:
//   CLK, RST               clock (rising edge), asynchronous active-high reset
//   MemReadM, MemWriteM    load / store request from the MEM stage
//   ALUOutM, WriteDataM    access address and store data
//   mem_rdata, mem_ready   memory read data and completion strobe
//   mem_req, mem_we        registered request and write-enable to memory
//   mem_addr, mem_wdata    registered address and store data to memory
//   StallM                 pipeline freeze (combinational)
//   ReadDataM              registered load result for MEM/WB
//   BusErrM                sticky timeout flag

module data_memory_access_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUOutM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  BusErrM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  // Remembers that both read and write were requested; such an access is
  // performed as a store but must return zero as its load result.
  logic                 both_q;

  // DONE deliberately drops the stall so the pipeline advances exactly once.
  assign StallM = (state == ACCESS) || ((state == IDLE) && (MemReadM || MemWriteM));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      cnt       <= '0;
      both_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReadM || MemWriteM) begin
            mem_addr  <= ALUOutM;
            mem_wdata <= WriteDataM;
            mem_we    <= MemWriteM;
            both_q    <= MemReadM && MemWriteM;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              ReadDataM <= mem_rdata;
            end else if (both_q) begin
              ReadDataM <= '0;
            end
            state <= DONE;
          end else if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            mem_req   <= 1'b0;
            BusErrM   <= 1'b1;
            ReadDataM <= '0;
            state     <= DONE;
          end else begin
            // Abort fires at TIMEOUT_CYCLES-1, so this never wraps.
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_access_controller.sv
// tb/tb_data_memory_access_controller.sv - directed self-checking bench for data_memory_access_controller

module tb_data_memory_access_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        BusErrM;

  int checks = 0;
  int errors = 0;
  int stalls;

  always #5 CLK = ~CLK;

  data_memory_access_controller dut (
    .CLK       (CLK),
    .RST       (RST),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .StallM    (StallM),
    .ReadDataM (ReadDataM),
    .BusErrM   (BusErrM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_buserr", 32'(BusErrM), 32'd0);

    // Zero-wait load: 2 stall cycles
    MemReadM = 1'b1; ALUOutM = 32'h100; #1;
    chk("ld0_stall_idle", 32'(StallM), 32'd1);
    tick();
    chk("ld0_req", 32'(mem_req), 32'd1);
    chk("ld0_we", 32'(mem_we), 32'd0);
    chk("ld0_addr", mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("ld0_stall_acc", 32'(StallM), 32'd1);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0; MemReadM = 1'b0; #1;
    chk("ld0_done_req", 32'(mem_req), 32'd0);
    chk("ld0_done_stall", 32'(StallM), 32'd0);
    chk("ld0_rdata", ReadDataM, 32'hDEADBEEF);
    tick();

    // Store with 3 wait cycles: 5 stall cycles, ReadDataM untouched
    stalls = 0;
    MemWriteM = 1'b1; ALUOutM = 32'h44; WriteDataM = 32'h12345678; #1;
    stalls += int'(StallM);
    tick();
    ALUOutM = 32'hFFFF; WriteDataM = 32'h0;
    chk("st3_we", 32'(mem_we), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'hAAAAAAAA;
      end
      #1;
      chk("st3_addr_hold", mem_addr, 32'h44);
      chk("st3_wdata_hold", mem_wdata, 32'h12345678);
      chk("st3_req_hold", 32'(mem_req), 32'd1);
      stalls += int'(StallM);
      tick();
    end
    mem_ready = 1'b0; MemWriteM = 1'b0; #1;
    stalls += int'(StallM);
    chk("st3_stall_count", 32'(stalls), 32'd5);
    chk("st3_done_req", 32'(mem_req), 32'd0);
    chk("st3_rdata_kept", ReadDataM, 32'hDEADBEEF);
    tick();

    // Timeout abort after 16 ACCESS cycles
    stalls = 0;
    MemReadM = 1'b1; ALUOutM = 32'h200; #1;
    stalls += int'(StallM);
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("to_req_hold", 32'(mem_req), 32'd1);
      chk("to_buserr_low", 32'(BusErrM), 32'd0);
      stalls += int'(StallM);
      tick();
    end
    MemReadM = 1'b0; #1;
    stalls += int'(StallM);
    chk("to_stall_count", 32'(stalls), 32'd17);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_buserr", 32'(BusErrM), 32'd1);
    chk("to_rdata_zero", ReadDataM, 32'h0);
    tick();
    // Following load completes normally, error stays sticky
    MemReadM = 1'b1; ALUOutM = 32'h300; tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D; tick();
    mem_ready = 1'b0; MemReadM = 1'b0; #1;
    chk("to_next_rdata", ReadDataM, 32'hCAFEF00D);
    chk("to_buserr_sticky", 32'(BusErrM), 32'd1);
    tick();

    // Back-to-back load then store; stray ready in IDLE and DONE
    MemReadM = 1'b1; ALUOutM = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ready = 1'b0; #1;
    chk("b2b_ld_req", 32'(mem_req), 32'd1);
    chk("b2b_ld_rdata_old", ReadDataM, 32'hCAFEF00D);
    tick();
    chk("b2b_ld_wait_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    tick();
    MemReadM = 1'b0; MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'h33;
    mem_ready = 1'b1; mem_rdata = 32'h44444444; #1;
    chk("b2b_ld_rdata", ReadDataM, 32'h22222222);
    chk("b2b_done_stall", 32'(StallM), 32'd0);
    chk("b2b_done_req", 32'(mem_req), 32'd0);
    tick();
    mem_ready = 1'b0; #1;
    chk("b2b_gap_req", 32'(mem_req), 32'd0);
    chk("b2b_gap_stall", 32'(StallM), 32'd1);
    chk("b2b_stray_rdata", ReadDataM, 32'h22222222);
    tick();
    chk("b2b_st_req", 32'(mem_req), 32'd1);
    chk("b2b_st_we", 32'(mem_we), 32'd1);
    chk("b2b_st_addr", mem_addr, 32'h20);
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ready = 1'b0; MemWriteM = 1'b0; #1;
    chk("b2b_st_rdata_kept", ReadDataM, 32'h22222222);
    tick();

    // Read and write together: store, load result forced to zero
    MemReadM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h30; WriteDataM = 32'h55;
    tick();
    chk("both_we", 32'(mem_we), 32'd1);
    chk("both_wdata", mem_wdata, 32'h55);
    mem_ready = 1'b1; mem_rdata = 32'h66666666;
    tick();
    mem_ready = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; #1;
    chk("both_rdata_zero", ReadDataM, 32'h0);
    tick();

    // Reset pulsed mid-ACCESS takes effect immediately
    MemReadM = 1'b1; ALUOutM = 32'h400;
    tick();
    chk("rst2_req_before", 32'(mem_req), 32'd1);
    MemReadM = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("rst2_req", 32'(mem_req), 32'd0);
    chk("rst2_stall", 32'(StallM), 32'd0);
    chk("rst2_rdata", ReadDataM, 32'h0);
    chk("rst2_buserr", 32'(BusErrM), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("rst2_idle_req", 32'(mem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
